// File: rtl/cordic_iter_ctrl_pkg.sv
// cordic_pkg: shared widths, arctangent table and controller state type for
// the iterative CORDIC engine.
//   W_EXT     external operand width (signed, 0x4000 = +pi/2 for angles)
//   W_INT     internal datapath width, W_EXT plus two LSB guard bits
//   ATAN_LUT  atan(2^-i) in internal angle units, 0x10000 = pi/2
//   cordic_state_e  IDLE / ITER / DONE
package cordic_pkg;

  localparam int W_EXT      = 16;
  localparam int W_INT      = 18;
  localparam int N_ITER_MAX = 16;

  localparam logic [W_INT-1:0] ATAN_LUT [0:N_ITER_MAX-1] = '{
    18'h08000, 18'h04B90, 18'h027ED, 18'h01444,
    18'h00A2C, 18'h00517, 18'h0028C, 18'h00146,
    18'h000A3, 18'h00051, 18'h00029, 18'h00014,
    18'h0000A, 18'h00005, 18'h00003, 18'h00001
  };

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } cordic_state_e;

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// cordic_iter_ctrl_if: operand/result handshake bundle of the iterative
// CORDIC engine.
//   in_valid/in_ready + x_in/y_in/z_in      operand side
//   out_valid/out_ready + x_out/y_out/z_out result side
//   busy, iter                              status / debug
// master = operand producer and result consumer, slave = the engine.
interface cordic_iter_ctrl_if;
  import cordic_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [W_EXT-1:0]        x_in;
  logic [W_EXT-1:0]        y_in;
  logic [W_EXT-1:0]        z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [W_EXT-1:0]        x_out;
  logic [W_EXT-1:0]        y_out;
  logic [W_EXT-1:0]        z_out;
  logic                    busy;
  logic [3:0]              iter;

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, busy, iter
  );

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, busy, iter
  );

endinterface

// File: rtl/cordic_iter_stage.sv
// cordic_iter_stage: one combinational CORDIC micro-rotation.
//   x, y, z   current internal vector and residual angle (W_INT bits)
//   angle     atan(2^-shift) for this step
//   shift     iteration index, used as the arithmetic shift amount
//   x_next, y_next, z_next  rotated vector and updated residual angle
// Direction is taken from the sign of z: rotate positive when z >= 0.
module cordic_iter_stage
  import cordic_pkg::*;
(
  input  logic [W_INT-1:0] x,
  input  logic [W_INT-1:0] y,
  input  logic [W_INT-1:0] z,
  input  logic [W_INT-1:0] angle,
  input  logic [3:0]       shift,
  output logic [W_INT-1:0] x_next,
  output logic [W_INT-1:0] y_next,
  output logic [W_INT-1:0] z_next
);

  // Barrel shifter: every shifted copy is formed straight from the input and
  // the shift amount picks one, so there is no chained ripple of muxes.
  logic [W_INT-1:0] x_sh [0:15];
  logic [W_INT-1:0] y_sh [0:15];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shift
      assign x_sh[gi] = $signed(x) >>> gi;
      assign y_sh[gi] = $signed(y) >>> gi;
    end
  endgenerate

  logic [W_INT-1:0] x_shifted;
  logic [W_INT-1:0] y_shifted;
  assign x_shifted = x_sh[shift];
  assign y_shifted = y_sh[shift];

  logic d;
  assign d = ~z[W_INT-1];

  // Each subtraction is an inverted operand plus a carry-in of one, so a
  // single adder per coordinate covers both rotation directions.
  logic [W_INT-1:0] x_term;
  logic [W_INT-1:0] y_term;
  logic [W_INT-1:0] a_term;
  logic [W_INT-1:0] cin_pos;
  logic [W_INT-1:0] cin_neg;

  assign y_term  = d ? ~y_shifted : y_shifted;  // X - (Y>>>i) when d
  assign x_term  = d ? x_shifted  : ~x_shifted; // Y - (X>>>i) when !d
  assign a_term  = d ? ~angle     : angle;      // Z - atan     when d
  assign cin_pos = {{(W_INT-1){1'b0}}, d};
  assign cin_neg = {{(W_INT-1){1'b0}}, ~d};

  assign x_next = x + y_term + cin_pos;
  assign y_next = y + x_term + cin_neg;
  assign z_next = z + a_term + cin_pos;

endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iterative rotation-mode CORDIC engine. A single shared
// micro-rotation stage is applied N_ITER times to the captured operand.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cordic_iter_ctrl_if.slave: operand handshake (in_*), result
//          handshake (out_*), busy and the debug iteration index.
// Timing: accept edge, N_ITER ITER cycles, then DONE holds the result until
// out_ready. in_ready is high only in IDLE, so operands offered while busy
// are never latched.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER = 16
)
(
  input  logic                clk,
  input  logic                rst_n,
  cordic_iter_ctrl_if.slave   bus
);

  localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

  cordic_state_e    state_reg;
  logic [3:0]       iter_reg;
  logic [W_INT-1:0] x_reg;
  logic [W_INT-1:0] y_reg;
  logic [W_INT-1:0] z_reg;
  logic [W_EXT-1:0] x_out_reg;
  logic [W_EXT-1:0] y_out_reg;
  logic [W_EXT-1:0] z_out_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [W_INT-1:0] x_next;
  logic [W_INT-1:0] y_next;
  logic [W_INT-1:0] z_next;

  cordic_iter_stage u_stage (
    .x      (x_reg),
    .y      (y_reg),
    .z      (z_reg),
    .angle  (ATAN_LUT[iter_reg]),
    .shift  (iter_reg),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      iter_reg      <= 4'd0;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      x_out_reg     <= '0;
      y_out_reg     <= '0;
      z_out_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg        <= {bus.x_in, 2'b00};
            y_reg        <= {bus.y_in, 2'b00};
            z_reg        <= {bus.z_in, 2'b00};
            iter_reg     <= 4'd0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= ITER;
          end
        end

        ITER: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          if (iter_reg == LAST_ITER) begin
            // Outputs are taken from the final rotation directly so they are
            // valid in the same cycle out_valid rises.
            x_out_reg     <= x_next[W_INT-1:2];
            y_out_reg     <= y_next[W_INT-1:2];
            z_out_reg     <= z_next[W_INT-1:2];
            out_valid_reg <= 1'b1;
            iter_reg      <= 4'd0;
            state_reg     <= DONE;
          end else begin
            iter_reg <= iter_reg + 4'd1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          iter_reg      <= 4'd0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.x_out     = x_out_reg;
  assign bus.y_out     = y_out_reg;
  assign bus.z_out     = z_out_reg;
  assign bus.busy      = busy_reg;
  assign bus.iter      = iter_reg;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: self-checking bench for the iterative CORDIC engine.
// Expected results come from a plain-integer CORDIC reference whose angle
// table is derived from $atan, plus hand-computed trig values with tolerance.
module tb_cordic_iter_ctrl;
  import cordic_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cordic_iter_ctrl_if bus ();

  cordic_iter_ctrl #(.N_ITER(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int atan_q [0:15];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] ez;
    int          tol_xy;
    int          tol_z;
  } vec_t;

  vec_t vecs [0:4];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [15:0] act,
                           input logic [15:0] exp, input int tol);
    int a;
    int e;
    int diff;
    a = int'($signed(act));
    e = int'($signed(exp));
    diff = (a > e) ? a - e : e - a;
    total++;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d +/- %0d", name, a, e, tol);
    end
  endtask

  function automatic int wrap18(input int v);
    logic signed [17:0] t;
    t = v[17:0];
    return int'(t);
  endfunction

  // Reference rotation straight from the algorithm description.
  task automatic ref_rotate(input logic [15:0] xi, input logic [15:0] yi,
                            input logic [15:0] zi, output logic [15:0] xo,
                            output logic [15:0] yo, output logic [15:0] zo);
    int x, y, z, nx, ny, nz;
    x = int'($signed(xi)) * 4;
    y = int'($signed(yi)) * 4;
    z = int'($signed(zi)) * 4;
    for (int i = 0; i < 16; i++) begin
      if (z >= 0) begin
        nx = x - (y >>> i);
        ny = y + (x >>> i);
        nz = z - atan_q[i];
      end else begin
        nx = x + (y >>> i);
        ny = y - (x >>> i);
        nz = z + atan_q[i];
      end
      x = wrap18(nx);
      y = wrap18(ny);
      z = wrap18(nz);
    end
    xo = 16'(x >>> 2);
    yo = 16'(y >>> 2);
    zo = 16'(z >>> 2);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", longint'(bus.in_ready), 1);
  endtask

  // Starts at a negedge; returns at the first negedge with out_valid high.
  task automatic run_op(input logic [15:0] xi, input logic [15:0] yi,
                        input logic [15:0] zi, output logic [15:0] xo,
                        output logic [15:0] yo, output logic [15:0] zo,
                        output int lat);
    wait_idle();
    bus.x_in     = xi;
    bus.y_in     = yi;
    bus.z_in     = zi;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    xo = bus.x_out;
    yo = bus.y_out;
    zo = bus.z_out;
  endtask

  task automatic rand_operand(output logic [15:0] xi, output logic [15:0] yi,
                              output logic [15:0] zi);
    int v;
    v  = int'($urandom_range(0, 2 * 32'h4D00)) - 32'h4D00;
    xi = 16'(v);
    v  = int'($urandom_range(0, 2 * 32'h4D00)) - 32'h4D00;
    yi = 16'(v);
    v  = int'($urandom_range(0, 2 * 32'h4000)) - 32'h4000;
    zi = 16'(v);
  endtask

  initial begin
    logic [15:0] xo, yo, zo, ex, ey, ez;
    logic [15:0] ax, ay, az;
    logic [15:0] bq_x [$];
    logic [15:0] bq_y [$];
    logic [15:0] bq_z [$];
    logic [15:0] ops [0:2][0:2];
    int          acc_t [$];
    int          lat;
    int          n;
    int          results;
    int          next_idx;
    logic        pending;
    logic        saw;
    real         pi;

    pi = 3.141592653589793;
    for (int i = 0; i < 16; i++)
      atan_q[i] = $rtoi($atan(1.0 / (2.0 ** i)) / (pi / 2.0) * 65536.0 + 0.5);

    vecs[0] = '{16'h4000, 16'h0000, 16'h0000, 16'h6965, 16'h0000, 16'h0000, 3, 2};
    vecs[1] = '{16'h4000, 16'h0000, 16'h2000, 16'h4A87, 16'h4A87, 16'h0000, 3, 2};
    vecs[2] = '{16'h4000, 16'h0000, 16'hE000, 16'h4A87, 16'hB579, 16'h0000, 3, 2};
    vecs[3] = '{16'h0000, 16'h4000, 16'h4000, 16'h969B, 16'h0000, 16'h0000, 6, 3};
    vecs[4] = '{16'h2000, 16'h2000, 16'hC000, 16'h34B3, 16'hCB4D, 16'h0000, 6, 3};

    // Reset state
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.z_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready",  longint'(bus.in_ready), 1);
    check("reset_out_valid", longint'(bus.out_valid), 0);
    check("reset_busy",      longint'(bus.busy), 0);
    check("reset_iter",      longint'(bus.iter), 0);
    check("reset_x_out",     longint'(bus.x_out), 0);
    check("reset_y_out",     longint'(bus.y_out), 0);
    check("reset_z_out",     longint'(bus.z_out), 0);

    // Table vectors: analytic values with tolerance, and exact reference.
    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].x, vecs[v].y, vecs[v].z, xo, yo, zo, lat);
      $display("vec %0d: x=%h y=%h z=%h -> x_out=%h y_out=%h z_out=%h lat=%0d",
               v, vecs[v].x, vecs[v].y, vecs[v].z, xo, yo, zo, lat);
      check("vec_latency", longint'(lat), 17);
      check_tol("vec_x", xo, vecs[v].ex, vecs[v].tol_xy);
      check_tol("vec_y", yo, vecs[v].ey, vecs[v].tol_xy);
      check_tol("vec_z", zo, vecs[v].ez, vecs[v].tol_z);
      ref_rotate(vecs[v].x, vecs[v].y, vecs[v].z, ex, ey, ez);
      check("vec_x_exact", longint'(xo), longint'(ex));
      check("vec_y_exact", longint'(yo), longint'(ey));
      check("vec_z_exact", longint'(zo), longint'(ez));
      @(negedge clk);
      check("vec_out_valid_drop", longint'(bus.out_valid), 0);
      check("vec_back_to_idle",   longint'(bus.in_ready), 1);
    end

    // Backpressure: DONE held for 10 cycles with a stray in_valid pulse.
    bus.out_ready = 1'b0;
    run_op(16'h3000, 16'h1000, 16'h1800, xo, yo, zo, lat);
    ref_rotate(16'h3000, 16'h1000, 16'h1800, ex, ey, ez);
    check("bp_latency", longint'(lat), 17);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", longint'(bus.out_valid), 1);
      check("bp_in_ready",  longint'(bus.in_ready), 0);
      check("bp_x_hold",    longint'(bus.x_out), longint'(ex));
      check("bp_y_hold",    longint'(bus.y_out), longint'(ey));
      check("bp_z_hold",    longint'(bus.z_out), longint'(ez));
      if (i == 3) begin
        bus.x_in = 16'h1111;
        bus.y_in = 16'h2222;
        bus.z_in = 16'h0333;
        bus.in_valid = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
    end
    $display("backpressure: x_out=%h y_out=%h z_out=%h held 10 cycles", bus.x_out, bus.y_out, bus.z_out);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", longint'(bus.out_valid), 0);
    check("bp_release_in_ready",  longint'(bus.in_ready), 1);
    check("bp_release_busy",      longint'(bus.busy), 0);
    @(negedge clk);
    check("bp_no_capture", longint'(bus.busy), 0);

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) rand_operand(ops[i][0], ops[i][1], ops[i][2]);
    wait_idle();
    bus.x_in = ops[0][0];
    bus.y_in = ops[0][1];
    bus.z_in = ops[0][2];
    bus.in_valid = 1'b1;
    next_idx = 1;
    pending = 1'b0;
    results = 0;
    for (int k = 0; k < 120 && results < 3; k++) begin
      if (pending) begin
        if (next_idx < 3) begin
          bus.x_in = ops[next_idx][0];
          bus.y_in = ops[next_idx][1];
          bus.z_in = ops[next_idx][2];
          next_idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
        pending = 1'b0;
      end
      if (bus.out_valid === 1'b1 && bq_x.size() > 0) begin
        ref_rotate(bq_x.pop_front(), bq_y.pop_front(), bq_z.pop_front(), ex, ey, ez);
        $display("b2b result %0d: x_out=%h y_out=%h z_out=%h", results, bus.x_out, bus.y_out, bus.z_out);
        check("b2b_x", longint'(bus.x_out), longint'(ex));
        check("b2b_y", longint'(bus.y_out), longint'(ey));
        check("b2b_z", longint'(bus.z_out), longint'(ez));
        results++;
      end
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
        bq_x.push_back(bus.x_in);
        bq_y.push_back(bus.y_in);
        bq_z.push_back(bus.z_in);
        acc_t.push_back(k);
        pending = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("b2b_results", longint'(results), 3);
    check("b2b_accepts", longint'(acc_t.size()), 3);
    if (acc_t.size() == 3) begin
      check("b2b_interval_1", longint'(acc_t[1] - acc_t[0]), 18);
      check("b2b_interval_2", longint'(acc_t[2] - acc_t[1]), 18);
    end

    // Reset asserted in the middle of ITER.
    wait_idle();
    bus.x_in = 16'h2345;
    bus.y_in = 16'h0123;
    bus.z_in = 16'h1234;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.iter !== 4'd7 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_iter7", longint'(bus.iter), 7);
    check("abort_busy_before", longint'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", longint'(bus.out_valid), 0);
    check("abort_in_ready",  longint'(bus.in_ready), 1);
    check("abort_busy",      longint'(bus.busy), 0);
    check("abort_iter",      longint'(bus.iter), 0);
    check("abort_x_out",     longint'(bus.x_out), 0);
    check("abort_y_out",     longint'(bus.y_out), 0);
    check("abort_z_out",     longint'(bus.z_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw = 1'b1;
    end
    $display("abort at iter 7: out_valid seen afterwards=%0d", saw);
    check("abort_no_out_valid", longint'(saw), 0);
    run_op(16'h1800, 16'hF000, 16'h3000, xo, yo, zo, lat);
    ref_rotate(16'h1800, 16'hF000, 16'h3000, ex, ey, ez);
    $display("after abort: x_out=%h y_out=%h z_out=%h lat=%0d", xo, yo, zo, lat);
    check("post_abort_latency", longint'(lat), 17);
    check("post_abort_x", longint'(xo), longint'(ex));
    check("post_abort_y", longint'(yo), longint'(ey));
    check("post_abort_z", longint'(zo), longint'(ez));
    @(negedge clk);

    // in_valid held through ITER with changing data: no capture, iter ramps.
    rand_operand(ax, ay, az);
    wait_idle();
    bus.x_in = ax;
    bus.y_in = ay;
    bus.z_in = az;
    bus.in_valid = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      check("hold_iter",     longint'(bus.iter), longint'(j));
      check("hold_busy",     longint'(bus.busy), 1);
      check("hold_in_ready", longint'(bus.in_ready), 0);
      bus.x_in = 16'($urandom);
      bus.y_in = 16'($urandom);
      bus.z_in = 16'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    ref_rotate(ax, ay, az, ex, ey, ez);
    $display("hold in_valid: x=%h y=%h z=%h -> x_out=%h y_out=%h z_out=%h",
             ax, ay, az, bus.x_out, bus.y_out, bus.z_out);
    check("hold_out_valid", longint'(bus.out_valid), 1);
    check("hold_x", longint'(bus.x_out), longint'(ex));
    check("hold_y", longint'(bus.y_out), longint'(ey));
    check("hold_z", longint'(bus.z_out), longint'(ez));
    @(negedge clk);
    check("hold_idle_busy", longint'(bus.busy), 0);

    // Randomised operands against the reference model.
    for (int t = 0; t < 20; t++) begin
      rand_operand(ax, ay, az);
      run_op(ax, ay, az, xo, yo, zo, lat);
      ref_rotate(ax, ay, az, ex, ey, ez);
      $display("rand %0d: x=%h y=%h z=%h -> x_out=%h y_out=%h z_out=%h lat=%0d",
               t, ax, ay, az, xo, yo, zo, lat);
      check("rand_latency", longint'(lat), 17);
      check("rand_x", longint'(xo), longint'(ex));
      check("rand_y", longint'(yo), longint'(ey));
      check("rand_z", longint'(zo), longint'(ez));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
